// File: rtl/phase_sweep_ctrl.sv
// phase_sweep_ctrl: steps a DDS phase increment from start_inc to stop_inc, holding each value for a dwell period.
module phase_sweep_ctrl #(
    parameter int PW = 19,
    parameter int DW = 24
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          loop,
    input  logic [PW-1:0] start_inc,
    input  logic [PW-1:0] stop_inc,
    input  logic [PW-1:0] step_inc,
    input  logic [DW-1:0] dwell,
    output logic [PW-1:0] phase_inc,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] start_q, start_d;
    logic [PW-1:0] stop_q, stop_d;
    logic [PW-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          loop_q, loop_d;
    logic          up_q, up_d;
    logic          done_q, done_d;
    logic          launch, boundary, clamp;
    logic [PW:0]   next_w;
    logic [DW-1:0] reload_w, reload_in_w;

    assign launch      = start && !abort;
    assign boundary    = cnt_q == '0;
    assign reload_w    = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
    assign reload_in_w = (dwell == '0) ? '0 : dwell - DW'(1);
    // one extra bit catches carry/borrow out of PW bits, which also forces the clamp
    assign next_w = up_q ? {1'b0, phase_q} + {1'b0, step_q} : {1'b0, phase_q} - {1'b0, step_q};
    assign clamp  = next_w[PW] || (step_q == '0) ||
                    (up_q ? (next_w[PW-1:0] >= stop_q) : (next_w[PW-1:0] <= stop_q));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            loop_q  <= 1'b0;
            up_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            up_q    <= up_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = launch ? RUN : IDLE;
            RUN:     state_d = abort ? IDLE : (boundary && clamp) ? LAST : RUN;
            LAST:    state_d = abort ? IDLE : boundary ? (loop_q ? RUN : IDLE) : LAST;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        up_d    = up_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (launch) begin
                start_d = start_inc;
                stop_d  = stop_inc;
                step_d  = step_inc;
                dwell_d = dwell;
                loop_d  = loop;
                up_d    = stop_inc >= start_inc;
                phase_d = start_inc;
                cnt_d   = reload_in_w;
            end
        end else if (!abort) begin
            cnt_d = boundary ? reload_w : cnt_q - DW'(1);
            if (boundary) begin
                if (state_q == RUN)
                    phase_d = clamp ? stop_q : next_w[PW-1:0];
                else if (loop_q)
                    phase_d = start_q;
                else
                    done_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = done_q;
        phase_inc = phase_q;
    end
endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// tb_phase_sweep_ctrl: table-driven sweeps plus loop/abort/reset sequences, checked through an expectation queue.
module tb_phase_sweep_ctrl;
    localparam int PW = 19;
    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          rst, start, abort, loop;
    logic [PW-1:0] start_inc, stop_inc, step_inc;
    logic [DW-1:0] dwell;
    logic [PW-1:0] phase_inc;
    logic          busy, done;

    phase_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .start_inc(start_inc), .stop_inc(stop_inc), .step_inc(step_inc), .dwell(dwell),
        .phase_inc(phase_inc), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [PW-1:0] ph;
        logic          bsy;
        logic          dn;
    } obs_t;

    typedef struct {
        logic [PW-1:0] s;
        logic [PW-1:0] e;
        logic [PW-1:0] st;
        logic [DW-1:0] dw;
        int            n;
        logic [PW-1:0] v[4];
    } vec_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [PW-1:0] ph, input logic b, input logic d);
        exp_q.push_back({ph, b, d});
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_next(input string name);
        obs_t a, e;
        a = {phase_inc, busy, done};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued, got phase_inc=%h busy=%b done=%b", name, phase_inc, busy, done);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got phase_inc=%h busy=%b done=%b, required phase_inc=%h busy=%b done=%b",
                         name, a.ph, a.bsy, a.dn, e.ph, e.bsy, e.dn);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int deff;
        deff = (v.dw == 0) ? 1 : int'(v.dw);
        start_inc = v.s;
        stop_inc  = v.e;
        step_inc  = v.st;
        dwell     = v.dw;
        loop      = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < v.n; i++)
            for (int k = 0; k < deff; k++)
                push(v.v[i], 1'b1, 1'b0);
        push(v.v[v.n-1], 1'b0, 1'b1);
        push(v.v[v.n-1], 1'b0, 1'b0);
        tick();
        check_next(name);
        // scramble inputs and re-pulse start while busy: neither may disturb the sweep
        start_inc = PW'($urandom);
        stop_inc  = PW'($urandom);
        step_inc  = PW'($urandom);
        dwell     = DW'($urandom_range(0, 5));
        loop      = 1'b1;
        tick();
        check_next(name);
        start = 1'b0;
        loop  = 1'b0;
        while (exp_q.size() > 0) begin
            tick();
            check_next(name);
        end
    endtask

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{100, 130, 10, 3, 4, '{100, 110, 120, 130}};
        tbl[1] = '{1000, 975, 10, 1, 4, '{1000, 990, 980, 975}};
        tbl[2] = '{'h7FFF0, 'h7FFFF, 'h20, 2, 2, '{'h7FFF0, 'h7FFFF, 0, 0}};
        tbl[3] = '{5, 8, 1, 0, 4, '{5, 6, 7, 8}};
        tbl[4] = '{50, 60, 0, 2, 2, '{50, 60, 0, 0}};
        tbl[5] = '{77, 77, 5, 2, 2, '{77, 77, 0, 0}};
        tbl[6] = '{300, 200, 0, 1, 2, '{300, 200, 0, 0}};
        tbl[7] = '{5, 2, 10, 1, 2, '{5, 2, 0, 0}};

        rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
        start_inc = '0; stop_inc = '0; step_inc = '0; dwell = '0;
        tick();
        tick();
        push('0, 1'b0, 1'b0);
        check_next("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // continuous sweep, then abort while 110 is held
        start_inc = 100; stop_inc = 130; step_inc = 10; dwell = 3; loop = 1'b1; start = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) begin
                push(100, 1'b1, 1'b0);
                if (r == 0) begin
                    push(110, 1'b1, 1'b0);
                    push(120, 1'b1, 1'b0);
                    push(130, 1'b1, 1'b0);
                end
            end
        exp_q.sort() with (item.ph);
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_q.pop_front());
        tick();
        start = 1'b0;
        check_next("loop");
        for (int i = 0; i < 14; i++) begin
            tick();
            check_next("loop");
        end
        push(110, 1'b1, 1'b0);
        tick();
        check_next("loop_wrap");
        abort = 1'b1;
        push(110, 1'b0, 1'b0);
        tick();
        abort = 1'b0;
        check_next("abort");
        push(110, 1'b0, 1'b0);
        tick();
        check_next("abort_hold");

        start = 1'b1; abort = 1'b1; loop = 1'b0;
        push(110, 1'b0, 1'b0);
        tick();
        start = 1'b0; abort = 1'b0;
        check_next("start_abort");
        push(110, 1'b0, 1'b0);
        tick();
        check_next("start_abort_hold");

        // asynchronous reset in the middle of a sweep
        start_inc = 100; stop_inc = 130; step_inc = 10; dwell = 3; start = 1'b1;
        push(100, 1'b1, 1'b0); push(100, 1'b1, 1'b0); push(100, 1'b1, 1'b0); push(110, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check_next("pre_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_next("pre_rst");
        end
        #2 rst = 1'b1;
        #1 push('0, 1'b0, 1'b0);
        check_next("rst_async");
        push('0, 1'b0, 1'b0);
        tick();
        check_next("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push('0, 1'b0, 1'b0);
            tick();
            check_next("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
